sdram_rd_engine: RTL

Parametrised SDRAM burst-read engine, the next generation of the single-bank fixed-burst reader. Accepts a read job (start bank/row/column, length in bursts) and requests the SDRAM bus from the arbiter. Once granted, it issues ACTIVE/READ/PRECHARGE sequences with configurable tRCD, tRP, CAS latency and burst length. It yields to refresh and crosses row and bank boundaries automatically, and sits beside the write engine and refresh module under the arbiter.

---
 rtl/sdram_pkg.sv | 25 ++
 rtl/sdram_rd_addr_gen.sv | 48 ++++
 rtl/sdram_rd_engine.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command encodings, engine state encoding and timing helpers
// shared by the read and write engines.
package sdram_pkg;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_PRECH = 4'b0010;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam int A10 = 10;
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_REQ   = 5'b00010,
    S_ACT   = 5'b00100,
    S_READ  = 5'b01000,
    S_PRECH = 5'b10000
  } state_t;
  function automatic int slot_len(input int cas_lat, input int burst_len);
    return cas_lat + burst_len + 1;
  endfunction
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/sdram_rd_addr_gen.sv
// sdram_rd_addr_gen: bank/row/column walker with row and bank wrap.
// SDRAM_PINGPONG_EN: bank wraps land in the half of the banks opposite the writer.
module sdram_rd_addr_gen
  import sdram_pkg::*;
#(
  parameter int ROW_W     = 13,
  parameter int COL_W     = 9,
  parameter int BANK_W    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  input  logic [BANK_W-1:0] ld_bank,
  input  logic [ROW_W-1:0]  ld_row,
  input  logic [COL_W-1:0]  ld_col,
`ifdef SDRAM_PINGPONG_EN
  input  logic [BANK_W-1:0] write_bank_addr,
`endif
  output logic [BANK_W-1:0] bank,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              row_end
);
  localparam logic [COL_W-1:0] COL_MASK = COL_W'(BURST_LEN - 1);
  logic [BANK_W-1:0] wrap_bank;
  assign row_end = col == ~COL_MASK;
`ifdef SDRAM_PINGPONG_EN
  assign wrap_bank = write_bank_addr + (BANK_W'(1) << (BANK_W - 1));
`else
  assign wrap_bank = bank + BANK_W'(1);
`endif
  always_ff @(posedge sysclk_100M or negedge rst_n)
    if (!rst_n) begin
      bank <= '0;
      row  <= '0;
      col  <= '0;
    end else if (load) begin
      bank <= ld_bank;
      row  <= ld_row;
      col  <= ld_col & ~COL_MASK;
    end else if (adv) begin
      col <= col + COL_W'(BURST_LEN);
      if (row_end) row <= row + ROW_W'(1);
      if (row_end && &row) bank <= wrap_bank;
    end
endmodule

// File: rtl/sdram_rd_engine.sv
// sdram_rd_engine: arbitrated SDRAM burst reader issuing ACTIVE/READ/PRECH sequences.
// SDRAM_PINGPONG_EN: adds write_bank_addr and steers bank wraps away from the writer.
module sdram_rd_engine
  import sdram_pkg::*;
#(
  parameter int ROW_W     = 13,
  parameter int COL_W     = 9,
  parameter int BANK_W    = 2,
  parameter int BURST_LEN = 4,
  parameter int CAS_LAT   = 3,
  parameter int TRCD      = 2,
  parameter int TRP       = 2,
  parameter int LEN_W     = 20
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              rd_start,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_busy,
  output logic              rd_done,
  output logic [3:0]        cmd_reg,
  output logic [ROW_W-1:0]  sdram_addr,
  output logic [BANK_W-1:0] sdram_bank_addr,
  input  logic              refresh_req,
  output logic              arbit_read_req,
  input  logic              arbit_read_ack,
  output logic              arbit_read_end,
  output logic              arbit_prech_end,
`ifdef SDRAM_PINGPONG_EN
  input  logic [BANK_W-1:0] write_bank_addr,
`endif
  output logic              data_vld
);
  localparam int SLOT = slot_len(CAS_LAT, BURST_LEN);
  localparam int CW = cnt_w(max3(SLOT, TRCD, TRP));
  localparam int VW = CAS_LAT + BURST_LEN - 1;
  localparam logic [ROW_W-1:0] ADDR_IDLE = ROW_W'(1) << A10;
  state_t state, nxt, after, after_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] remain;
  logic [BANK_W-1:0] bank;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [VW-1:0] vld_sr;
  logic [3:0] cmd;
  logic row_end, load, slot_end, last, prech_last;
  assign load = state == S_IDLE && rd_start && rd_len != '0;
  assign slot_end = state == S_READ && cnt == CW'(SLOT - 1);
  assign last = remain == LEN_W'(1);
  assign prech_last = state == S_PRECH && cnt == CW'(TRP - 1);
  sdram_rd_addr_gen #(
    .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .BURST_LEN(BURST_LEN)
  ) u_addr (
    .sysclk_100M(sysclk_100M), .rst_n(rst_n), .load(load), .adv(slot_end),
    .ld_bank(rd_bank), .ld_row(rd_row), .ld_col(rd_col),
`ifdef SDRAM_PINGPONG_EN
    .write_bank_addr(write_bank_addr),
`endif
    .bank(bank), .row(row), .col(col), .row_end(row_end)
  );
  always_ff @(posedge sysclk_100M or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      after <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      after <= after_nxt;
      cnt   <= cnt_nxt;
    end
  always_comb begin
    nxt = state;
    after_nxt = after;
    cnt_nxt = cnt + CW'(1);
    cmd = CMD_NOP;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (load) nxt = S_REQ;
      end
      S_REQ: begin
        cnt_nxt = '0;
        if (arbit_read_ack) nxt = S_ACT;
      end
      S_ACT: begin
        cmd = cnt == '0 ? CMD_ACT : CMD_NOP;
        if (cnt == CW'(TRCD - 1)) begin
          nxt = S_READ;
          cnt_nxt = '0;
        end
      end
      S_READ: begin
        cmd = cnt == '0 ? CMD_READ : CMD_NOP;
        if (slot_end) begin
          cnt_nxt = '0;
          if (last || refresh_req || row_end) nxt = S_PRECH;
          after_nxt = last ? S_IDLE : refresh_req ? S_REQ : S_ACT;
        end
      end
      S_PRECH: begin
        cmd = cnt == '0 ? CMD_PRECH : CMD_NOP;
        if (prech_last) begin
          nxt = after;
          cnt_nxt = '0;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge sysclk_100M or negedge rst_n)
    if (!rst_n) remain <= '0;
    else if (load) remain <= rd_len;
    else if (slot_end) remain <= remain - LEN_W'(1);
  // outputs trail the state by one cycle; data_vld also covers CAS latency plus capture
  always_ff @(posedge sysclk_100M or negedge rst_n)
    if (!rst_n) begin
      cmd_reg         <= CMD_NOP;
      sdram_addr      <= ADDR_IDLE;
      sdram_bank_addr <= '0;
      arbit_read_req  <= 1'b0;
      arbit_read_end  <= 1'b1;
      arbit_prech_end <= 1'b0;
      rd_busy         <= 1'b0;
      rd_done         <= 1'b0;
      vld_sr          <= '0;
      data_vld        <= 1'b0;
    end else begin
      cmd_reg         <= cmd;
      sdram_addr      <= cmd == CMD_ACT ? row : cmd == CMD_READ ? ROW_W'(col) : ADDR_IDLE;
      sdram_bank_addr <= bank;
      arbit_read_req  <= state == S_REQ && !arbit_read_ack;
      arbit_read_end  <= state == S_REQ && arbit_read_ack ? 1'b0 : slot_end && last ? 1'b1 : arbit_read_end;
      arbit_prech_end <= prech_last;
      rd_busy         <= nxt != S_IDLE;
      rd_done         <= prech_last && after == S_IDLE;
      vld_sr          <= {vld_sr[VW-2:0], cmd_reg == CMD_READ};
      data_vld        <= |vld_sr[VW-1:CAS_LAT-1];
    end
endmodule
